// File: rtl/ntt_pkg.sv
// Shared constants for the NTT arithmetic blocks: standard moduli and the
// Barrett multiplier helper.
package ntt_pkg;

   localparam int KYBER_Q     = 3329;
   localparam int DILITHIUM_Q = 8380417;

   // Barrett constant M = floor(2^k / q).
   function automatic logic [63:0] barrett_m(input int unsigned q, input int unsigned k);
      return (64'd1 << k) / 64'(q);
   endfunction

endpackage

// File: rtl/barrett_pipe_slot.sv
// One valid/ready register slice. It loads whenever it is empty or its
// downstream neighbour takes its current contents this cycle.
module barrett_pipe_slot #(
   parameter int W        = 8,
   parameter bit RST_DATA = 1'b0
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         up_ready,
   output logic         valid,
   output logic [W-1:0] data,
   input  logic         dn_ready
);

   assign up_ready = !valid || dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        valid <= 1'b0;
      else if (up_ready) valid <= up_valid;
   end

   // Only the output slice clears its payload; inner payloads stay unreset.
   generate
      if (RST_DATA) begin : g_rst
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                    data <= '0;
            else if (up_ready && up_valid) data <= up_data;
         end
      end else begin : g_nrst
         always_ff @(posedge clk) begin
            if (up_ready && up_valid) data <= up_data;
         end
      end
   endgenerate

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reduction r = x mod Q with valid/ready
// handshakes and a sideband tag carried alongside each operand.
module barrett_reduce_pipe
   import ntt_pkg::*;
#(
   parameter int QW   = 12,
   parameter int Q    = KYBER_Q,
   parameter int XW   = 2*QW,
   parameter int K    = 2*QW,
   parameter int TAGW = 8
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XW-1:0]   x,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [QW-1:0]   r,
   output logic [TAGW-1:0] out_tag
);

   localparam int P1W = XW + K + 1;     // x*M product
   localparam int P2W = K + QW;         // t*Q product
   localparam int TW  = XW - QW + 1;    // t <= x/Q < 2^(XW-QW+1)
   localparam int RW  = QW + 2;         // r0 < 3Q fits here
   localparam int W1  = TAGW + XW + P1W;
   localparam int W2  = TAGW + XW + P2W;
   localparam int W3  = TAGW + QW;

   localparam logic [63:0]    M     = barrett_m(Q, K);
   localparam logic [P1W-1:0] M_EXT = P1W'(M);

   logic            s1_valid, s2_valid, s3_valid;
   logic            s2_up_ready, s3_up_ready;
   logic [W1-1:0]   s1_data;
   logic [W2-1:0]   s2_data;
   logic [W3-1:0]   s3_data;

   logic [TAGW-1:0] s1_tag, s2_tag;
   logic [XW-1:0]   s1_x, s2_x;
   logic [P1W-1:0]  s1_xm;
   logic [P2W-1:0]  s2_tq;
   logic [TW-1:0]   t;
   logic [P2W-1:0]  tq;
   logic [RW-1:0]   r0, r_next;

   assign {s1_tag, s1_x, s1_xm} = s1_data;
   assign {s2_tag, s2_x, s2_tq} = s2_data;

   barrett_pipe_slot #(.W(W1), .RST_DATA(1'b0)) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (in_valid),
      .up_data  ({in_tag, x, P1W'(x) * M_EXT}),
      .up_ready (in_ready),
      .valid    (s1_valid),
      .data     (s1_data),
      .dn_ready (s2_up_ready)
   );

   assign t  = TW'(s1_xm >> K);
   assign tq = P2W'(t) * P2W'(Q);

   barrett_pipe_slot #(.W(W2), .RST_DATA(1'b0)) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s1_valid),
      .up_data  ({s1_tag, s1_x, tq}),
      .up_ready (s2_up_ready),
      .valid    (s2_valid),
      .data     (s2_data),
      .dn_ready (s3_up_ready)
   );

   // The true difference is below 3Q, so modular arithmetic at RW bits is exact.
   assign r0 = RW'(s2_x) - RW'(s2_tq);

   always_comb begin
      r_next = r0;
      if (r0 >= RW'(2*Q))  r_next = r0 - RW'(2*Q);
      else if (r0 >= RW'(Q)) r_next = r0 - RW'(Q);
   end

   barrett_pipe_slot #(.W(W3), .RST_DATA(1'b1)) u_s3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s2_valid),
      .up_data  ({s2_tag, QW'(r_next)}),
      .up_ready (s3_up_ready),
      .valid    (s3_valid),
      .data     (s3_data),
      .dn_ready (out_ready)
   );

   assign out_valid      = s3_valid;
   assign {out_tag, r}   = s3_data;

endmodule

// File: doc/barrett_reduce_pipe.md
BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

Interface
REQ-001 Parameter QW, default 12: bit width of modulus q.
REQ-002 Parameter Q, default 3329: modulus value; 2^(QW-1) < Q < 2^QW, Q odd.
REQ-003 Parameter XW, default 2*QW: input operand width.
REQ-004 Parameter K, default 2*QW: Barrett shift; localparam M = floor(2^K / Q) (5039 at defaults).
REQ-005 Parameter TAGW, default 8: sideband tag width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  x and in_tag are valid.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 x  input  XW  unsigned operand, full range 0..2^XW-1.
REQ-011 in_tag  input  TAGW  opaque tag carried with x.
REQ-012 out_valid  output  1  r and out_tag are valid.
REQ-013 out_ready  input  1  downstream accepts output.
REQ-014 r  output  QW  x mod Q, always in 0..Q-1.
REQ-015 out_tag  output  TAGW  tag of the operand producing r.

Function
REQ-016 Transfer occurs on a cycle where valid and ready are both high; in_ready and out_valid are the only handshake outputs.
REQ-017 Three-stage pipeline; S1 registers x*M and x; S2 registers t*Q and x with t = (x*M) >> K; S3 registers final r.
REQ-018 Latency: an accepted operand appears on out_valid exactly 3 cycles later when out_ready is held high.
REQ-019 Throughput: one result per cycle with out_ready high, no bubbles inserted.
REQ-020 Stage i loads when stage i is empty or stage i+1 advances this cycle; stage 3 advances on out_ready; in_ready = !s1_valid || s1_advance.
REQ-021 Backpressure: with out_ready low, held stages keep data and tag unchanged, and empty stages still fill (bubble collapse); at most 3 operands are held.
REQ-022 A stall in progress never drops, duplicates or reorders an operand; out_valid is not withdrawn once asserted until the transfer completes.
REQ-023 r0 = x - t*Q is computed at width QW+2; for any x < 2^XW, r0 < 3Q.
REQ-024 Correction: subtract Q when r0 >= 2Q (twice) or when r0 >= Q (once), so 0 <= r < Q for the full input range, not only for x < Q^2.
REQ-025 Multiplier products are at least XW+K+1 bits wide (x*M) and K+QW bits wide (t*Q); intermediate truncation below these widths is forbidden.
REQ-026 Tags travel in lockstep with their operand through all stages.

Reset
REQ-027 While rst_n is low, all stage valid flags clear and out_valid = 0; r and out_tag read 0.
REQ-028 Reset mid-operation discards every in-flight operand; no output appears for operands accepted before the reset.
REQ-029 in_ready = 1 in the first cycle after reset is released.

Structure
REQ-030 The shared package ntt_pkg holds KYBER_Q = 3329, DILITHIUM_Q = 8380417 and the constant function computing M from Q and K.
REQ-031 Datapath registers are not reset; only valid flags are reset, together with the r and out_tag output registers.
REQ-032 One sub-module, barrett_pipe_slot, implements the valid/ready register slice and is instantiated three times.
REQ-033 Multiplies and subtracts are plain RTL operators; the block contains no vendor primitives.

Verification
REQ-034 Defaults, x=0 with out_ready=1 -> r=0 three cycles after acceptance.
REQ-035 Defaults, x=11075584 (3328^2) -> r=1; x=16777215 -> r=2384 (checks the single correction path).
REQ-036 Defaults, 1000 random x in 0..2^24-1 back-to-back with tags 0..255 incrementing -> each r equals the golden x mod 3329, tags come out in order, and no idle cycles occur.
REQ-037 out_ready=0 for 6 cycles while 5 operands are offered -> exactly 3 are accepted and in_ready drops; after release, all 3 outputs emerge in order, followed by the remaining 2.
REQ-038 rst_n pulsed low with 3 operands in flight -> out_valid=0 immediately and no stale result appears afterwards.
REQ-039 Q=8380417, QW=23, TAGW=4 with random 46-bit x -> r matches the golden x mod Q, including cases that exercise the double-correction path.
